// File: rtl/truth_table_scanner.sv
// truth_table_scanner
//   Walks every input vector of an N_IN-input single-output function, holds
//   each vector for SETTLE cycles, then samples the response. It builds the
//   captured truth table, counts minterms and compares against a table that is
//   latched at start.
//
//   Handshake: start is a level sampled at the clock edge and is only honoured
//   in IDLE. abort is only honoured in SCAN and wins over a coincident final
//   sample. done is a single-cycle pulse and is high exactly while the FSM sits
//   in FINISH.
//
//   Ports
//     clk, rst_n  : rising-edge clock, asynchronous active-low reset
//     start       : begin a scan (IDLE only)
//     abort       : terminate a scan in progress
//     exp_table   : expected truth table, bit i = response for vector i
//     resp        : output of the function under test
//     vec         : applied vector, vec[N_IN-1] = first function input
//     busy        : scan in progress
//     done        : one-cycle pulse when a scan completes
//     tbl         : captured truth table (the name "table" is a reserved word)
//     ones        : number of 1 responses
//     mismatch    : sticky, some response differed from the expected table
//     first_bad   : index of the first mismatching vector, 0 when none
//     dbg_state   : current FSM state (0 IDLE, 1 SCAN, 2 FINISH)
module truth_table_scanner #(
  parameter int N_IN   = 5,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   exp_table,
  input  logic                 resp,
  output logic [N_IN-1:0]      vec,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   tbl,
  output logic [N_IN:0]        ones,
  output logic                 mismatch,
  output logic [N_IN-1:0]      first_bad,
  output logic [1:0]           dbg_state
);

  localparam int T  = 2**N_IN;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [T-1:0]      tbl_q, tbl_d;
  logic [N_IN:0]     ones_q, ones_d;
  logic              mismatch_q, mismatch_d;
  logic [N_IN-1:0]   first_bad_q, first_bad_d;
  logic [T-1:0]      exp_q, exp_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tbl_d       = tbl_q;
    ones_d      = ones_q;
    mismatch_d  = mismatch_q;
    first_bad_d = first_bad_q;
    exp_d       = exp_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_SCAN;
          vec_d       = '0;
          busy_d      = 1'b1;
          tbl_d       = '0;
          ones_d      = '0;
          mismatch_d  = 1'b0;
          first_bad_d = '0;
          exp_d       = exp_table;
          cnt_d       = '0;
        end
      end
      S_SCAN: begin
        if (abort) begin
          // Abort beats a coincident final sample: nothing is captured.
          state_d = S_IDLE;
          busy_d  = 1'b0;
          vec_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          tbl_d[vec_q] = resp;
          ones_d       = ones_q + {{N_IN{1'b0}}, resp};
          if ((resp != exp_q[vec_q]) && !mismatch_q) begin
            mismatch_d  = 1'b1;
            first_bad_d = vec_q;
          end
          cnt_d = '0;
          if (vec_q == VEC_LAST) begin
            vec_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_FINISH;
          end else begin
            vec_d = vec_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        vec_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      vec_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tbl_q       <= '0;
      ones_q      <= '0;
      mismatch_q  <= 1'b0;
      first_bad_q <= '0;
      exp_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tbl_q       <= tbl_d;
      ones_q      <= ones_d;
      mismatch_q  <= mismatch_d;
      first_bad_q <= first_bad_d;
      exp_q       <= exp_d;
      cnt_q       <= cnt_d;
    end
  end

  assign vec       = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign tbl       = tbl_q;
  assign ones      = ones_q;
  assign mismatch  = mismatch_q;
  assign first_bad = first_bad_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
module tb_truth_table_scanner;
  localparam int N = 5;
  localparam int T = 32;
  localparam int W = T + (N + 1) + 1 + N;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 0: SETTLE=2, SOP function ----------------
  logic           start0 = 1'b0, abort0 = 1'b0;
  logic [T-1:0]   exp_tab0 = '0;
  logic           resp0;
  logic [N-1:0]   vec0, first_bad0;
  logic           busy0, done0, mismatch0;
  logic [T-1:0]   tbl0;
  logic [N:0]     ones0;
  logic [1:0]     st0;

  // V'W'Z' + WY'Z + VXZ with vec[4]=V .. vec[0]=Z
  function automatic logic f_ut(input logic [N-1:0] v);
    return (~v[4] & ~v[3] & ~v[0]) | (v[3] & ~v[1] & v[0]) | (v[4] & v[2] & v[0]);
  endfunction
  assign resp0 = f_ut(vec0);

  truth_table_scanner #(.N_IN(N), .SETTLE(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .exp_table(exp_tab0), .resp(resp0), .vec(vec0), .busy(busy0),
    .done(done0), .tbl(tbl0), .ones(ones0), .mismatch(mismatch0),
    .first_bad(first_bad0), .dbg_state(st0)
  );

  // ---------------- DUT 1: SETTLE=1, resp tied 1, exp 0 ----------------
  logic           start1 = 1'b0;
  logic [N-1:0]   vec1, first_bad1;
  logic           busy1, done1, mismatch1;
  logic [T-1:0]   tbl1;
  logic [N:0]     ones1;
  logic [1:0]     st1;

  truth_table_scanner #(.N_IN(N), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0),
    .exp_table({T{1'b0}}), .resp(1'b1), .vec(vec1), .busy(busy1),
    .done(done1), .tbl(tbl1), .ones(ones1), .mismatch(mismatch1),
    .first_bad(first_bad1), .dbg_state(st1)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp1_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [T-1:0] t, input int o,
                                        input logic m, input int fb);
    return {t, (N+1)'(o), m, N'(fb)};
  endfunction

  task automatic check_result(input string tag, input logic [W-1:0] e,
                              input logic [T-1:0] t, input logic [N:0] o,
                              input logic m, input logic [N-1:0] fb);
    chk({tag, "_table"},     t,  e[W-1 -: T]);
    chk({tag, "_ones"},      o,  e[2*N+1 -: N+1]);
    chk({tag, "_mismatch"},  m,  e[N]);
    chk({tag, "_first_bad"}, fb, e[N-1:0]);
  endtask

  // Monitors: pop on every done pulse, done must never last two cycles.
  logic done0_prev = 1'b0, done1_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      done0_prev = 1'b0;
      done1_prev = 1'b0;
    end else begin
      if (done0) begin
        chk("done0_width", done0_prev, 1'b0);
        chk("done0_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0)
          check_result("scan0", exp_q.pop_front(), tbl0, ones0, mismatch0, first_bad0);
      end
      if (done1) begin
        chk("done1_width", done1_prev, 1'b0);
        chk("done1_expected", exp1_q.size() != 0, 1'b1);
        if (exp1_q.size() != 0)
          check_result("scan1", exp1_q.pop_front(), tbl1, ones1, mismatch1, first_bad1);
      end
      done0_prev = done0;
      done1_prev = done1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_scan0(input logic [T-1:0] et);
    @(negedge clk);
    exp_tab0 = et;
    start0   = 1'b1;
    @(negedge clk);
    start0   = 1'b0;
  endtask

  // Counts negedges with busy high; optionally re-pulses start mid-scan.
  task automatic count_busy0(input int poke_at, output int n);
    n = 0;
    while (busy0 && n < 200) begin
      start0 = (n == poke_at);
      n++;
      @(negedge clk);
    end
    start0 = 1'b0;
  endtask

  task automatic wait_vec0(input int v);
    int k = 0;
    while (vec0 !== N'(v) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("wait_vec0", vec0, v);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_vec"},       vec0,       0);
    chk({tag, "_busy"},      busy0,      0);
    chk({tag, "_done"},      done0,      0);
    chk({tag, "_table"},     tbl0,       0);
    chk({tag, "_ones"},      ones0,      0);
    chk({tag, "_mismatch"},  mismatch0,  0);
    chk({tag, "_first_bad"}, first_bad0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    // Reset with clocks running.
    repeat (3) @(negedge clk);
    check_all_zero("reset0");
    chk("reset1_table", tbl1, 0);
    chk("reset1_busy",  busy1, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean full scan; exp_table changes after start must be ignored.
    exp_q.push_back(pack(32'hA2A02255, 11, 1'b0, 0));
    start_scan0(32'hA2A02255);
    exp_tab0 = '0;
    count_busy0(-1, n);
    chk("scan0_busy_cycles", n, 64);
    chk("scan0_done_at_end", done0, 1);
    @(negedge clk);
    chk("scan0_idle_after", st0, 0);

    // Expected table with errors at vectors 3 and 13.
    exp_q.push_back(pack(32'hA2A02255, 11, 1'b1, 3));
    start_scan0(32'hA2A0025D);
    count_busy0(-1, n);
    chk("scan0b_busy_cycles", n, 64);
    repeat (2) @(negedge clk);

    // SETTLE=1 instance with resp tied high.
    exp1_q.push_back(pack(32'hFFFFFFFF, 32, 1'b1, 0));
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (busy1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("scan1_busy_cycles", n, 32);
    chk("scan1_done_at_end", done1, 1);
    repeat (2) @(negedge clk);

    // Abort at vec=10: no done, partial capture of vectors 0..9 only.
    start_scan0(32'hA2A02255);
    wait_vec0(10);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    chk("abort_busy",  busy0, 0);
    chk("abort_vec",   vec0,  0);
    chk("abort_done",  done0, 0);
    chk("abort_table", tbl0,  32'h0000_0255);
    chk("abort_ones",  ones0, 5);
    repeat (3) @(negedge clk);
    exp_q.push_back(pack(32'hA2A02255, 11, 1'b0, 0));
    start_scan0(32'hA2A02255);
    count_busy0(-1, n);
    chk("after_abort_busy_cycles", n, 64);
    repeat (2) @(negedge clk);

    // Abort coinciding with the final sample: sample discarded, no done.
    start_scan0(32'hA2A02255);
    wait_vec0(31);
    @(negedge clk);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    chk("abort_last_busy",  busy0, 0);
    chk("abort_last_done",  done0, 0);
    chk("abort_last_table", tbl0,  32'h22A0_2255);
    chk("abort_last_ones",  ones0, 10);
    // abort in IDLE does nothing.
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    chk("abort_idle_table", tbl0, 32'h22A0_2255);
    chk("abort_idle_state", st0,  0);
    repeat (2) @(negedge clk);

    // start re-pulsed mid-scan is ignored.
    exp_q.push_back(pack(32'hA2A02255, 11, 1'b0, 0));
    start_scan0(32'hA2A02255);
    count_busy0(20, n);
    chk("restart_busy_cycles", n, 64);
    repeat (2) @(negedge clk);

    // Reset mid-scan: everything clears at once, no done afterwards.
    start_scan0(32'hA2A02255);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    chk("midreset_stays_idle", st0, 0);

    chk("pending0", exp_q.size(), 0);
    chk("pending1", exp1_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
- Sequential stimulus/response engine: the reader for the 5-input combinational function blocks (e.g. circuit2_1-style SOP logic).
- Drives every input vector to the function under test and samples its single-bit response.
- Assembles the full truth table, counts minterms and compares against an expected table.
- Replaces hand-written per-vector testbench sequences; also usable on-chip as a built-in self-test of small logic cones.

Parameters:
N_IN, 5, number of function inputs; the table holds 2^N_IN bits.
SETTLE, 2, clock cycles each vector is held before the response is sampled; must be >= 1.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous reset, active-low
start  input  1  begin a scan; honoured only in IDLE
abort  input  1  terminate a scan in progress
exp_table  input  2^N_IN  expected truth table; bit i is the response for vector i
resp  input  1  output of the function under test
vec  output  N_IN  applied vector; vec[N_IN-1] = first function input (V), vec[0] = last (Z)
busy  output  1  scan in progress
done  output  1  one-cycle pulse when a scan completes
table  output  2^N_IN  captured truth table
ones  output  N_IN+1  number of 1 responses (minterm count)
mismatch  output  1  sticky: some resp differed from exp_table
first_bad  output  N_IN  index of first mismatching vector; 0 when none

Behaviour:
- Reset: rst_n low asynchronously clears state to IDLE and all outputs to 0: vec, busy, done, table, ones, mismatch, first_bad. The latched expected table and settle counter also clear.
- All outputs are registered.
- States:
  - IDLE -> SCAN on start.
  - SCAN -> FINISH after the last sample.
  - SCAN -> IDLE on abort.
  - FINISH -> IDLE unconditionally.
- Start (at an edge, in IDLE with start=1):
  - vec <= 0, busy <= 1.
  - table, ones, mismatch, first_bad cleared.
  - exp_table latched internally; later changes to exp_table are ignored until the next start.
  - Settle counter <= 0.
- SCAN timing:
  - Each vector is held for SETTLE cycles.
  - At the edge where the settle counter = SETTLE-1, resp is sampled:
    - table[vec] <= resp.
    - ones increments when resp=1.
    - On the first resp != exp[vec], mismatch <= 1 and first_bad <= vec; later mismatches leave first_bad unchanged.
  - At that same edge, vec increments and the counter resets.
  - Full scan = 2^N_IN * SETTLE cycles of busy.
- End of scan:
  - When the sample is taken at vec = 2^N_IN-1, vec wraps to 0, busy <= 0, state FINISH.
  - In FINISH, done = 1 for exactly one cycle.
  - table, ones, mismatch and first_bad hold until the next start.
- start while busy or in FINISH is ignored (no restart, no clear).
- abort in SCAN: at the next edge, state IDLE, busy <= 0, vec <= 0, and no done pulse. Partial table/ones/mismatch hold. abort in IDLE or FINISH has no effect.
- If abort and the final sample coincide, abort wins: the sample is discarded and there is no done.
- ones width N_IN+1 holds the all-ones count 2^N_IN without overflow.
- Reset asserted mid-scan aborts immediately; no done.

Test Plan:
- Reset: rst_n=0 with clocks running -> vec=0, busy=0, done=0, table=0, ones=0, mismatch=0, first_bad=0.
- Full scan, N_IN=5, SETTLE=2, resp = V'W'Z' + WY'Z + VXZ, exp_table=32'hA2A02255:
  - busy high 64 cycles, then done pulses one cycle.
  - table=32'hA2A02255, ones=11 (minterms 0,2,4,6,9,13,21,23,25,29,31).
  - mismatch=0, first_bad=0.
- Same function with exp_table=32'hA2A0025D -> mismatch=1, first_bad=3 (not 13); table still 32'hA2A02255.
- resp tied 1, exp_table=0, SETTLE=1 -> busy 32 cycles, table=32'hFFFFFFFF, ones=32, mismatch=1, first_bad=0.
- abort asserted while vec=10 -> next cycle busy=0, vec=0, no done, table bits 10..31 = 0. A subsequent start completes a clean scan.
- start pulsed mid-scan -> ignored, single done at the original 64-cycle point. rst_n dropped mid-scan -> all outputs 0 immediately, no done.
